// File: rtl/fabric_config_loader_if.sv
// Bitstream word handshake and pass-start strobe between the programming port and the config loader.
interface fabric_config_loader_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output start, word_in, word_valid, input word_ready);
  modport slave  (input start, word_in, word_valid, output word_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Serialises bitstream words LSB-first into one clb_tile column chain, then strobes set; CRC check under CFG_LOADER_CRC_EN.
// Latency: 1 LOAD + WORD_W shift cycles per word, then SET and DONE; word_valid low stalls in LOAD with no shifting.
module fabric_config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  fabric_config_loader_if.slave   cfg,
  output logic                    shift_out,
  output logic                    shift_en,
  output logic                    set_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, SET, DONE
`ifdef CFG_LOADER_CRC_EN
    , CHECK
`endif
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_nxt;
  logic [WB_W-1:0]   word_bits;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              word_end;

  assign shreg_nxt = shreg >> 1;
  assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_end  = (word_bits == WB_W'(1));

`ifdef CFG_LOADER_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  // shift_out holds the bit currently on the chain, so it is the CRC input.
  assign crc_nxt = {crc[14:0], 1'b0} ^ ((crc[15] ^ shift_out) ? 16'h1021 : 16'h0000);
  assign cfg.word_ready = (state == LOAD) || (state == CHECK);
`else
  assign cfg.word_ready = (state == LOAD);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      word_bits <= '0;
      bit_cnt   <= '0;
      shift_out <= 1'b0;
      shift_en  <= 1'b0;
      set_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      err       <= 1'b0;
      crc       <= 16'hFFFF;
`endif
    end else begin
      shift_out <= 1'b0;
      shift_en  <= 1'b0;
      set_out   <= 1'b0;
      done      <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg.start) begin
            state <= LOAD;
            busy  <= 1'b1;
`ifdef CFG_LOADER_CRC_EN
            crc   <= 16'hFFFF;
`endif
          end
        end
        LOAD: begin
          if (cfg.word_valid) begin
            shreg     <= cfg.word_in;
            word_bits <= WB_W'(WORD_W);
            state     <= SHIFT;
            shift_en  <= 1'b1;
            shift_out <= cfg.word_in[0];
          end
        end
        SHIFT: begin
          shreg     <= shreg_nxt;
          word_bits <= word_bits - 1'b1;
          bit_cnt   <= bit_cnt + 1'b1;
`ifdef CFG_LOADER_CRC_EN
          crc       <= crc_nxt;
`endif
          // Chain length wins over word length: leftover high bits of a partial word are dropped.
          if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
            state   <= CHECK;
`else
            state   <= SET;
            set_out <= 1'b1;
`endif
          end else if (word_end) begin
            state <= LOAD;
          end else begin
            shift_en  <= 1'b1;
            shift_out <= shreg_nxt[0];
          end
        end
        SET: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
`ifdef CFG_LOADER_CRC_EN
        CHECK: begin
          if (cfg.word_valid) begin
            if (cfg.word_in[15:0] == crc) begin
              state   <= SET;
              set_out <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboard bench: a 40-bit and a 32-bit column loader; the driver queues timed expected output events, a negedge monitor checks them.
module tb_fabric_config_loader;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fabric_config_loader_if #(.WORD_W(32)) ifa ();
  fabric_config_loader_if #(.WORD_W(32)) ifb ();

  logic a_out, a_en, a_set, a_busy, a_done, a_err;
  logic b_out, b_en, b_set, b_busy, b_done, b_err;

  fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut_a (
    .clk(clk), .rst(rst), .cfg(ifa),
    .shift_out(a_out), .shift_en(a_en), .set_out(a_set),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(32)) dut_b (
    .clk(clk), .rst(rst), .cfg(ifb),
    .shift_out(b_out), .shift_en(b_en), .set_out(b_set),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  // v = {set_out, done, shift_en, shift_out, err}
  typedef struct {
    int         cyc;
    bit         b;
    logic [4:0] v;
  } tok_t;

  tok_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nsh[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h (cyc %0d)", nm, got, req, cyc);
    end
  endtask

  task automatic push_tok(input int c, input bit b, input logic [4:0] v);
    tok_t tk;
    tk.cyc = c;
    tk.b   = b;
    tk.v   = v;
    expq.push_back(tk);
  endtask

  task automatic check_tok(input bit b, input logic [4:0] v);
    tok_t tk;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output dut=%0d cyc=%0d got=%b required=none", b, cyc, v);
    end else begin
      tk = expq.pop_front();
      if (tk.b !== b || tk.cyc != cyc || tk.v !== v) begin
        n_bad++;
        $display("FAIL out_event got dut=%0d cyc=%0d v=%b required dut=%0d cyc=%0d v=%b",
                 b, cyc, v, tk.b, tk.cyc, tk.v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_en || a_set || a_done) check_tok(1'b0, {a_set, a_done, a_en, a_out, a_err});
    if (b_en || b_set || b_done) check_tok(1'b1, {b_set, b_done, b_en, b_out, b_err});
    if (a_en) nsh[0]++;
    if (b_en) nsh[1]++;
  end

  task automatic set_in(input bit b, input logic s, input logic v, input logic [31:0] w);
    if (b) begin
      ifb.start = s; ifb.word_valid = v; ifb.word_in = w;
    end else begin
      ifa.start = s; ifa.word_valid = v; ifa.word_in = w;
    end
  endtask

  // {set_out, done, shift_en, shift_out, err, busy, word_ready}
  function automatic logic [6:0] outs(input bit b);
    if (b) return {b_set, b_done, b_en, b_out, b_err, b_busy, ifb.word_ready};
    return {a_set, a_done, a_en, a_out, a_err, a_busy, ifa.word_ready};
  endfunction

`ifdef CFG_LOADER_CRC_EN
  function automatic logic [15:0] crc_of(input bit bits[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (bits[i]) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  // One configuration pass. stall: LOAD cycles with word_valid low before the second word.
  // restart_at/rst_after: cycle offset to re-pulse start / number of shifts before rst (-1 = never).
  task automatic run_pass(input bit b, input int clen, input logic [31:0] w0, input logic [31:0] w1,
                          input int stall, input int restart_at, input int rst_after, input bit crc_good);
    logic [31:0] words[$];
    logic [31:0] cur;
    bit          bits[$];
    int          nwords, t, idx, n, wi, stall_left, m;
    logic        val, st, rd;
    bit          finished;

    nwords = (clen + 31) / 32;
    words.push_back(w0);
    if (nwords > 1) words.push_back(w1);
    for (int i = 0; i < clen; i++) begin
      cur = words[i / 32];
      bits.push_back(cur[i % 32]);
    end

    @(negedge clk); #1;
    m      = cyc;
    nsh[b] = 0;

    t   = m + 1;
    idx = 0;
    for (int k = 0; k < nwords; k++) begin
      t += 1 + ((k == 1) ? stall : 0);
      n = (clen - idx < 32) ? clen - idx : 32;
      for (int j = 0; j < n; j++) begin
        if (rst_after < 0 || idx < rst_after) push_tok(t, b, {3'b001, bits[idx], 1'b0});
        t++;
        idx++;
      end
    end
    if (rst_after < 0) begin
`ifdef CFG_LOADER_CRC_EN
      words.push_back({16'h0000, crc_good ? crc_of(bits) : (crc_of(bits) ^ 16'h0001)});
      if (crc_good) begin
        push_tok(t + 1, b, 5'b10000);
        push_tok(t + 2, b, 5'b01000);
      end else begin
        push_tok(t + 1, b, 5'b01001);
      end
`else
      push_tok(t, b, 5'b10000);
      push_tok(t + 1, b, 5'b01000);
`endif
    end

    wi         = 0;
    stall_left = stall;
    finished   = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      if (rst_after >= 0 && k == rst_after + 1) rst = 1'b1;
      if (rst_after >= 0 && k == rst_after + 2) begin
        chk("reset_mid_outputs", 32'(outs(b)), 32'h0);
        rst = 1'b0;
      end
      if (rst_after >= 0 && k == rst_after + 8) begin
        finished = 1'b1;
      end else if (rst_after < 0 && k > 2 && expq.size() == 0) begin
        finished = 1'b1;
      end else begin
        st  = (k == 0) || (k == restart_at);
        val = (wi < words.size()) && !(wi == 1 && stall_left > 0);
        rd  = b ? ifb.word_ready : ifa.word_ready;
        if (wi == 1 && stall_left > 0 && rd) begin
          chk("stall_no_shift", 32'(b ? b_en : a_en), 32'h0);
          stall_left--;
        end
        set_in(b, st, val, (wi < words.size()) ? words[wi] : 32'h0);
        @(posedge clk);
        if (val && rd) wi++;
        @(negedge clk); #1;
      end
    end
    set_in(b, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pass_timeout dut=%0d got=%0d_pending_events required=0", b, expq.size());
      expq.delete();
    end
    chk("shift_count", 32'(nsh[b]), 32'((rst_after < 0) ? clen : rst_after));
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_pass", 32'(outs(b)), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs_a", 32'(outs(1'b0)), 32'h0);
    chk("reset_outputs_b", 32'(outs(1'b1)), 32'h0);
    rst = 1'b0;

    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, -1, -1, 1'b1);
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 5, -1, -1, 1'b1);
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, 10, -1, 1'b1);
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, -1, 20, 1'b1);
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, -1, -1, 1'b1);
    run_pass(1'b1, 32, 32'hFFFFFFFF, 32'h00000000, 0, -1, -1, 1'b1);
    run_pass(1'b0, 40, 32'h12345678, 32'hFFFFFF3C, 0, -1, -1, 1'b1);
`ifdef CFG_LOADER_CRC_EN
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, -1, -1, 1'b0);
    run_pass(1'b0, 40, 32'hA5A5A5A5, 32'h000000C3, 0, -1, -1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Sequences the configuration of one column of clb_tile instances.
- Accepts bitstream words over a valid/ready handshake and serialises them LSB-first into the column's config shift chain.
- After exactly CHAIN_LEN bits it pulses the set strobe so every tile latches its config, then reports completion.
- Sits between the external programming interface and the top tile's shift_in_from_north / set_in_from_north pins.

Parameters:
- WORD_W, 32, width of incoming bitstream words.
- CHAIN_LEN, 1024, total config bits in the column chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- clk  input  1  fabric clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a configuration pass; sampled only in IDLE.
- word_in  input  WORD_W  bitstream word.
- word_valid  input  1  word_in valid.
- word_ready  output  1  loader accepts word_in this cycle.
- shift_out  output  1  serial config bit to the chain's shift_in.
- shift_en  output  1  chain shifts this cycle; also drives tile cen during config.
- set_out  output  1  one-cycle latch strobe to the chain's set_in.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of pass.
- err  output  1  one-cycle pulse with done on a failed pass (CRC feature only).

Behaviour:
- All outputs are driven from registered state and data. There is no combinational path from any input to any output except word_ready, which is a decode of state only.
- Reset, or rst asserted at any point including mid-pass:
  - next state IDLE.
  - shreg=0, bit_cnt=0, word_bits=0.
  - every output 0.
  - No set_out is ever produced for a partially shifted chain.
- States: IDLE, LOAD, SHIFT, SET, DONE. With the optional feature, CHECK is added.
- IDLE: start=1 -> LOAD. start while busy is ignored.
- LOAD:
  - word_ready=1, shift_en=0.
  - On word_valid&word_ready: shreg<=word_in, word_bits<=WORD_W, -> SHIFT.
  - word_valid low: stay in LOAD indefinitely (stall).
- SHIFT, each cycle:
  - shift_en=1, shift_out=shreg[0].
  - shreg<=shreg>>1, word_bits--, bit_cnt++.
  - If bit_cnt==CHAIN_LEN-1 this cycle (last bit): -> SET, or -> CHECK with the feature enabled.
  - Else if word_bits==1 (word exhausted): -> LOAD.
  - Else stay in SHIFT.
- Partial final word: the unused high bits are discarded. Exactly CHAIN_LEN shift_en cycles occur per pass.
- Per-word cost is one LOAD cycle (minimum) plus WORD_W SHIFT cycles.
- SET: set_out=1 for exactly one cycle, -> DONE.
- DONE: done=1 for one cycle; bit_cnt cleared; -> IDLE.
- shift_out=0 whenever shift_en=0.
- word_valid outside LOAD (and outside CHECK) is ignored; no word is consumed.

Optional Feature:
- Macro: CFG_LOADER_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register, one bit per shift_en cycle, input = shift_out) is computed over all CHAIN_LEN bits.
  - After the last bit -> CHECK: word_ready=1, wait for one word and compare word_in[15:0] to the CRC.
  - Match: -> SET (normal path).
  - Mismatch: -> DONE with err=1 alongside done; set_out never asserted.
  - CRC is reinitialised on start and on reset.
- Undefined: no CHECK state, no CRC logic, err tied to 0.

Test Plan:
- Reset, then CHAIN_LEN=40, WORD_W=32, start; words 0xA5A5A5A5 and 0x000000C3 with valid always high.
  - Required: 40 shift_en cycles; shift_out sequence is 1,0,1,0,0,1,0,1... then 1,1,0,0,0,0,1,1.
  - Exactly one LOAD gap between the two words.
  - set_out 1 cycle after the last bit; done 1 cycle after set_out.
  - Total 1+32+1+8+1+1 cycles from start.
- Same pass with word_valid held low 5 cycles before the second word.
  - Required: shift_en=0 and word_ready=1 for those 5 cycles; bit order unchanged; still exactly 40 shifts.
- start pulsed again during SHIFT.
  - Required: ignored; done pulses exactly once.
- rst asserted after 20 shifts.
  - Required: next cycle all outputs 0, set_out never asserted.
  - A fresh start then completes a full 40-bit pass.
- CHAIN_LEN=32 (exact word multiple), one word 0xFFFFFFFF.
  - Required: 32 shifts of 1, no second LOAD, straight to SET.
- CFG_LOADER_CRC_EN: pass a correct CRC word.
  - Required: set_out=1, err=0.
  - Repeat with CRC bit0 flipped: no set_out; done=1 and err=1 in the same cycle.
